// File: rtl/scoreboard_pkg.sv
// Shared constants and the event-entry type for the scoreboard register block.
// Optional per-event timestamp field is present when SCOREBOARD_EVT_TIMESTAMP_EN is defined.
package scoreboard_pkg;

    // Byte offsets within the responder's 256-byte window (only [4:2] decoded).
    localparam logic [4:0] SB_REG_CTRL   = 5'h00;
    localparam logic [4:0] SB_REG_SCORE  = 5'h04;
    localparam logic [4:0] SB_REG_EVENT  = 5'h08;
    localparam logic [4:0] SB_REG_STATUS = 5'h0C;

    localparam int SB_CTRL_RUN    = 0;
    localparam int SB_CTRL_CLEAR  = 1;
    localparam int SB_CTRL_IRQ_EN = 2;

    localparam int SB_STAT_EMPTY  = 5;
    localparam int SB_STAT_OVF    = 6;

    localparam int SB_EVT_VALID   = 8;

    localparam logic [7:0] SB_SCORE_MAX = 8'd99;

    typedef struct packed {
`ifdef SCOREBOARD_EVT_TIMESTAMP_EN
        logic [15:0] ts;
`endif
        logic [3:0]  code;
    } sb_evt_t;

    function automatic logic [7:0] sb_sat(input logic [7:0] v);
        return (v > SB_SCORE_MAX) ? SB_SCORE_MAX : v;
    endfunction

endpackage

// File: rtl/scoreboard_evt_fifo.sv
// Small synchronous FIFO for button events; a pop in the same cycle frees room for a push when full.
module scoreboard_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/scoreboard_wb_regs.sv
// Wishbone classic register block: scores, run/IRQ control and a drained event FIFO.
// Define SCOREBOARD_EVT_TIMESTAMP_EN to store a 16-bit cycle timestamp with each event.
module scoreboard_wb_regs
    import scoreboard_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ev_valid_i,
    input  logic [3:0]  ev_code_i,
    output logic [7:0]  score_home_o,
    output logic [7:0]  score_away_o,
    output logic        run_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          selected, req, wr, rd;
    logic [4:0]    off;
    logic          irq_en_q, ovf_q;
    logic          fifo_full, fifo_empty, pop, ev_drop;
    logic [CW-1:0] fifo_count;
    sb_evt_t       ev_in, ev_head;
    logic [31:0]   rdata;

    assign selected = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // ~ack gates the request so each access is sampled exactly once
    assign req      = wbs_stb_i & wbs_cyc_i & selected & ~wbs_ack_o;
    assign wr       = req & wbs_we_i;
    assign rd       = req & ~wbs_we_i;
    assign off      = {wbs_adr_i[4:2], 2'b00};
    assign pop      = rd & (off == SB_REG_EVENT) & ~fifo_empty;
    assign ev_drop  = ev_valid_i & fifo_full & ~pop;

`ifdef SCOREBOARD_EVT_TIMESTAMP_EN
    logic [15:0] ts_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            ts_q <= '0;
        else
            ts_q <= ts_q + 16'd1;
    end

    assign ev_in = '{ts: ts_q, code: ev_code_i};
`else
    assign ev_in = '{code: ev_code_i};
`endif

    scoreboard_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sb_evt_t))
    ) u_evt_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (ev_valid_i),
        .pop   (pop),
        .din   (ev_in),
        .dout  (ev_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rdata = '0;
        case (off)
            SB_REG_CTRL: begin
                rdata[SB_CTRL_RUN]    = run_o;
                rdata[SB_CTRL_IRQ_EN] = irq_en_q;
            end
            SB_REG_SCORE:
                rdata[15:0] = {score_away_o, score_home_o};
            SB_REG_EVENT: begin
                if (!fifo_empty) begin
                    rdata[3:0]          = ev_head.code;
                    rdata[SB_EVT_VALID] = 1'b1;
`ifdef SCOREBOARD_EVT_TIMESTAMP_EN
                    rdata[31:16]        = ev_head.ts;
`endif
                end
            end
            SB_REG_STATUS: begin
                rdata[4:0]           = 5'(fifo_count);
                rdata[SB_STAT_EMPTY] = fifo_empty;
                rdata[SB_STAT_OVF]   = ovf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            run_o        <= 1'b0;
            irq_en_q     <= 1'b0;
            ovf_q        <= 1'b0;
            irq_o        <= 1'b0;
            score_home_o <= '0;
            score_away_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : '0;

            if (wr && off == SB_REG_CTRL && wbs_sel_i[0]) begin
                run_o    <= wbs_dat_i[SB_CTRL_RUN];
                irq_en_q <= wbs_dat_i[SB_CTRL_IRQ_EN];
                if (wbs_dat_i[SB_CTRL_CLEAR]) begin
                    score_home_o <= '0;
                    score_away_o <= '0;
                end
            end

            if (wr && off == SB_REG_SCORE) begin
                if (wbs_sel_i[0])
                    score_home_o <= sb_sat(wbs_dat_i[7:0]);
                if (wbs_sel_i[1])
                    score_away_o <= sb_sat(wbs_dat_i[15:8]);
            end

            // A fresh drop wins over a same-cycle software clear
            if (ev_drop)
                ovf_q <= 1'b1;
            else if (wr && off == SB_REG_STATUS && wbs_sel_i[0] && wbs_dat_i[SB_STAT_OVF])
                ovf_q <= 1'b0;

            irq_o <= irq_en_q & (~fifo_empty | ovf_q);
        end
    end

endmodule

// File: doc/scoreboard_wb_regs.md
# scoreboard_wb_regs

- Wishbone classic responder giving the management core register access to the scoreboard.
- Holds the home/away scores and the run/IRQ controls, and drives them to the display core.
- Buffers button events from the scoreboard core in a small FIFO that software drains by reading, with an interrupt when events are pending.
- Sits inside `user_proj_scoreboard` on the Caravel Wishbone port, beside the display/button logic.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: responder selects when `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2, range 2..16.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low; the wrapper drives it from inverted `wb_rst_i`.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address; `[4:2]` selects the register.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `ev_valid_i` in 1: one-cycle event strobe from the button logic.
- `ev_code_i` in 4: event code, sampled when `ev_valid_i` is high.
- `score_home_o`, `score_away_o` out 8 each: binary scores, 0..99.
- `run_o` out 1: game clock enable.
- `irq_o` out 1: level interrupt.

## Operation
Register map (offset, access, fields):
- 0x00 CTRL RW: `[0]` run, `[1]` clear (write 1 zeroes both scores; reads 0), `[2]` irq_en.
- 0x04 SCORE RW: `[7:0]` home, `[15:8]` away.
  - Byte lanes are honoured per `wbs_sel_i`.
  - A written byte above 99 saturates to 99.
- 0x08 EVENT RO: a read pops one FIFO entry.
  - `[3:0]` code, `[8]` valid=1, `[31:16]` timestamp (see Configuration).
  - A read when the FIFO is empty returns 0 and has no side effect.
- 0x0C STATUS: `[4:0]` count (RO), `[5]` empty (RO), `[6]` overflow (sticky; write 1 to clear).
- Offsets 0x10–0x1C and unselected base addresses:
  - In-base offsets 0x10–0x1C are acked with read data 0; writes are ignored.
  - Accesses outside the base address are not acked.
- Event push: on `ev_valid_i`, if count < `FIFO_DEPTH`, the entry is stored. If the FIFO is full and there is no pop in the same cycle, the event is dropped and overflow is set.
- Simultaneous push and pop when full: the pop frees an entry and the push is accepted; count is unchanged and overflow is not set.
- `irq_o = irq_en & (~empty | overflow)`.
- Reset values:
  - All registers, FIFO pointers and count are 0; overflow is 0; the timestamp counter is 0.
  - Outputs `wbs_ack_o`, `wbs_dat_o`, `irq_o`, `run_o`, `score_home_o` and `score_away_o` are all 0 after reset.
- Reset mid-transaction: ack is aborted; the master must retry.

## Timing
- A request is sampled at edge k when `stb & cyc & selected & ~wbs_ack_o`.
- At edge k: a write commits, read data is registered, and an EVENT read pops.
- `wbs_ack_o` is high for exactly one cycle, from edge k to edge k+1. Latency is 1 cycle.
- Maximum throughput is 1 access per 2 cycles.
- `wbs_dat_o` is valid only while ack is high and is 0 otherwise.
- Score, run and irq outputs are registered and reflect a committed write one cycle after edge k.
- A CTRL clear takes effect at edge k. Scores read as 0 on the next access.
- `irq_o` updates one cycle after the push, pop or overflow change that causes it.

## Configuration
- `SCOREBOARD_EVT_TIMESTAMP_EN` defined:
  - A 16-bit free-running cycle counter is added. It wraps from 0xFFFF to 0.
  - The counter value is stored with each pushed event and returned in EVENT `[31:16]`.
- `SCOREBOARD_EVT_TIMESTAMP_EN` undefined: the counter and the stored field are absent, and EVENT `[31:16]` reads 0.

## Structure
- Package `scoreboard_pkg` holds:
  - register offset constants (`SB_REG_CTRL/SCORE/EVENT/STATUS`);
  - CTRL/STATUS bit-position constants;
  - `SB_SCORE_MAX` = 99;
  - the event-entry typedef (code plus optional timestamp).
- Sub-module `scoreboard_evt_fifo`:
  - synchronous FIFO with push/pop/count/full/empty;
  - parameterised by depth and width;
  - async active-low reset.

## Test plan
- Reset with any stimulus held, then release:
  - all outputs are 0;
  - STATUS read returns 0x20 (empty=1).
- Write SCORE=0x0000_3A63 with sel=4'b0011, then read it back:
  - read returns 0x0000_3A63;
  - `score_home_o`=99, `score_away_o`=58;
  - ack is high exactly one cycle.
- Write SCORE byte values 0xC8 and 0x64:
  - both bytes saturate to 99 (0x63);
  - then write CTRL=0x2: both scores become 0 and CTRL reads 0.
- Push codes 1,2,3,4,5 with `FIFO_DEPTH`=4 and irq_en=1:
  - `irq_o` rises one cycle after the first push;
  - STATUS reads count=4, overflow=1;
  - four EVENT reads return codes 1..4 with bit8 set; the fifth read returns 0.
- Fill the FIFO to full, then assert `ev_valid_i` in the same cycle as an EVENT read:
  - count stays 4;
  - overflow stays 0.
- Address outside the base (0x3000_0100): no ack.
- Address at offset 0x14: ack with read data 0.
- With `SCOREBOARD_EVT_TIMESTAMP_EN`: an event pushed 10 cycles after reset reads back a timestamp of 10.
